// File: rtl/risc_core_param.sv
// Parametrised multi-cycle accumulator CPU core with a ready/wait memory handshake.
// Define RISC_CORE_TRACE_EN to add the retire_vld/retire_pc/retire_op trace outputs.
module risc_core_param #(
  parameter int DW = 8,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy,
  output logic          halted,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc
`ifdef RISC_CORE_TRACE_EN
  ,
  output logic          retire_vld,
  output logic [AW-1:0] retire_pc,
  output logic [2:0]    retire_op
`endif
);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_EX   = 3'd3,
    S_RD   = 3'd4,
    S_WR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_pc, w_pc_next;
  logic [DW-1:0] r_acc, w_acc_next;
  logic [DW-1:0] r_ir0, w_ir0_next;
  logic [DW-1:0] r_ir1, w_ir1_next;
  logic [2*DW-4:0] w_oa_full;
  logic [AW-1:0] w_oa;
  logic [2:0]    w_op;

  assign w_op      = r_ir0[DW-1:DW-3];
  assign w_oa_full = {r_ir0[DW-4:0], r_ir1};
  assign w_oa      = w_oa_full[AW-1:0];

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_acc_next   = r_acc;
    w_ir0_next   = r_ir0;
    w_ir1_next   = r_ir1;
    case (r_state)
      S_RST: w_state_next = S_F0;
      S_F0: begin
        if (mem_rdy) begin
          w_ir0_next   = mem_rdata;
          w_pc_next    = r_pc + AW'(1);
          w_state_next = S_F1;
        end
      end
      S_F1: begin
        if (mem_rdy) begin
          w_ir1_next   = mem_rdata;
          w_pc_next    = r_pc + AW'(1);
          w_state_next = S_EX;
        end
      end
      S_EX: begin
        case (w_op)
          OP_HLT: w_state_next = S_HALT;
          OP_SKZ: begin
            if (r_acc == '0) w_pc_next = r_pc + AW'(2);
            w_state_next = S_F0;
          end
          OP_JMP: begin
            w_pc_next    = w_oa;
            w_state_next = S_F0;
          end
          OP_STO:  w_state_next = S_WR;
          default: w_state_next = S_RD;
        endcase
      end
      S_RD: begin
        if (mem_rdy) begin
          case (w_op)
            OP_ADD:  w_acc_next = r_acc + mem_rdata;
            OP_AND:  w_acc_next = r_acc & mem_rdata;
            OP_XOR:  w_acc_next = r_acc ^ mem_rdata;
            default: w_acc_next = mem_rdata;
          endcase
          w_state_next = S_F0;
        end
      end
      S_WR: begin
        if (mem_rdy) w_state_next = S_F0;
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RST;
      r_pc    <= '0;
      r_acc   <= '0;
      r_ir0   <= '0;
      r_ir1   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_acc   <= w_acc_next;
      r_ir0   <= w_ir0_next;
      r_ir1   <= w_ir1_next;
    end
  end

  // Bus outputs depend only on registered state, so wait states cannot glitch them.
  assign mem_rd    = (r_state == S_F0) || (r_state == S_F1) || (r_state == S_RD);
  assign mem_wr    = (r_state == S_WR);
  assign mem_addr  = ((r_state == S_RD) || (r_state == S_WR)) ? w_oa : r_pc;
  assign mem_wdata = r_acc;
  assign halted    = (r_state == S_HALT);
  assign pc        = r_pc;
  assign acc       = r_acc;

`ifdef RISC_CORE_TRACE_EN
  logic          w_retire;
  logic [AW-1:0] r_w0_pc;
  logic          r_retire_vld;
  logic [AW-1:0] r_retire_pc;
  logic [2:0]    r_retire_op;

  assign w_retire = ((r_state == S_EX) && ((w_op == OP_HLT) || (w_op == OP_SKZ) || (w_op == OP_JMP)))
                  || (((r_state == S_RD) || (r_state == S_WR)) && mem_rdy);

  // The pulse is registered so that mem_rdy never reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w0_pc      <= '0;
      r_retire_vld <= 1'b0;
      r_retire_pc  <= '0;
      r_retire_op  <= '0;
    end else begin
      if ((r_state == S_F0) && mem_rdy) r_w0_pc <= r_pc;
      r_retire_vld <= w_retire;
      if (w_retire) begin
        r_retire_pc <= r_w0_pc;
        r_retire_op <= w_op;
      end
    end
  end

  assign retire_vld = r_retire_vld;
  assign retire_pc  = r_retire_pc;
  assign retire_op  = r_retire_op;
`endif

endmodule

// File: tb/tb_risc_core_param.sv
// Bench for risc_core_param: directed programs plus random programs and random wait states,
// compared against an instruction-level interpreter of the same memory image.
module tb_risc_core_param;
  localparam int DW  = 8;
  localparam int AW  = 13;
  localparam int MSZ = 1 << AW;
  localparam int DMASK = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rdy = 1'b0;
  logic          halted;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
`ifdef RISC_CORE_TRACE_EN
  logic          retire_vld;
  logic [AW-1:0] retire_pc;
  logic [2:0]    retire_op;
`endif

  always #5 clk = ~clk;

  risc_core_param #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .halted(halted), .pc(pc), .acc(acc)
`ifdef RISC_CORE_TRACE_EN
    , .retire_vld(retire_vld), .retire_pc(retire_pc), .retire_op(retire_op)
`endif
  );

  logic [DW-1:0] mem [MSZ];
  logic [DW-1:0] mm  [MSZ];
  int checks = 0;
  int passed = 0;
  int rdy_pct = 100;
  bit block_wr = 0;
  int waits = 0;
  int m_acc, m_pc, m_cycles, last_cyc;
  logic [AW-1:0] rd_log[$];
  int exp_ret[$];
  int got_ret[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Memory model: drives rdy/rdata at negedge, commits writes that will complete at the next posedge.
  task automatic responder();
    bit prev_hold = 0;
    logic [31:0] prev_bus = '0;
    forever begin
      @(negedge clk);
      if (prev_hold && !rst)
        chk("bus_hold", {9'd0, mem_rd, mem_wr, mem_addr, mem_wdata}, prev_bus);
      if (!rst) chk("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
      if (block_wr && mem_wr) mem_rdy = 1'b0;
      else mem_rdy = ($urandom_range(99) < rdy_pct);
      mem_rdata = mem_rdy ? mem[mem_addr] : DW'($urandom);
      if (!rst && mem_wr && mem_rdy) mem[mem_addr] = mem_wdata;
      if (!rst && mem_rd && mem_rdy) rd_log.push_back(mem_addr);
      if (!rst && (mem_rd || mem_wr) && !mem_rdy) waits++;
      prev_hold = !rst && (mem_rd || mem_wr) && !mem_rdy;
      prev_bus  = {9'd0, mem_rd, mem_wr, mem_addr, mem_wdata};
`ifdef RISC_CORE_TRACE_EN
      if (retire_vld) got_ret.push_back((int'(retire_pc) << 3) | int'(retire_op));
`endif
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MSZ; i++) mem[i] = '0;
  endtask

  task automatic put_ins(input int addr, input int op, input int oa);
    mem[addr]     = DW'((op << (DW - 3)) | (oa >> DW));
    mem[addr + 1] = DW'(oa & DMASK);
  endtask

  // Instruction-level interpreter: whole instructions per step, 3 or 4 cycles each.
  task automatic model_run();
    int p, a, w0, w1, op, oa, steps;
    bit done;
    p = 0; a = 0; steps = 0; done = 0; m_cycles = 0;
    exp_ret.delete();
    for (int i = 0; i < MSZ; i++) mm[i] = mem[i];
    while (!done && steps < 1000) begin
      w0 = int'(mm[p]);
      w1 = int'(mm[(p + 1) % MSZ]);
      op = w0 >> (DW - 3);
      oa = (((w0 & ((1 << (DW - 3)) - 1)) << DW) | w1) % MSZ;
      exp_ret.push_back((p << 3) | op);
      p = (p + 2) % MSZ;
      steps++;
      case (op)
        0: begin done = 1; m_cycles += 3; end
        1: begin if (a == 0) p = (p + 2) % MSZ; m_cycles += 3; end
        2: begin a = (a + int'(mm[oa])) & DMASK; m_cycles += 4; end
        3: begin a = a & int'(mm[oa]); m_cycles += 4; end
        4: begin a = a ^ int'(mm[oa]); m_cycles += 4; end
        5: begin a = int'(mm[oa]); m_cycles += 4; end
        6: begin mm[oa] = DW'(a); m_cycles += 4; end
        default: begin p = oa; m_cycles += 3; end
      endcase
    end
    m_acc = a;
    m_pc  = p;
  endtask

  task automatic run_prog(input string name, input int pct);
    int cyc;
    rdy_pct = pct;
    model_run();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; waits = 0; rd_log.delete(); got_ret.delete();
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
    end
    chk({name, "_reached_halt"}, {31'd0, halted}, 32'd1);
    last_cyc = cyc - 1;
    chk({name, "_cycles"}, last_cyc, m_cycles + waits);
    chk({name, "_acc"}, acc, m_acc);
    chk({name, "_pc"}, pc, m_pc);
    @(negedge clk); #1;
    for (int i = 'h100; i < 'h110; i++)
      chk($sformatf("%s_mem_%0h", name, i), mem[i], mm[i]);
`ifdef RISC_CORE_TRACE_EN
    chk({name, "_retire_count"}, got_ret.size(), exp_ret.size());
    for (int i = 0; i < got_ret.size() && i < exp_ret.size(); i++)
      chk($sformatf("%s_retire_%0d", name, i), got_ret[i], exp_ret[i]);
`endif
  endtask

  task automatic load_prog_a();
    clear_mem();
    put_ins(0, 5, 'h100);
    put_ins(2, 2, 'h101);
    put_ins(4, 6, 'h102);
    put_ins(6, 0, 0);
    mem['h100] = 8'h7F;
    mem['h101] = 8'h02;
  endtask

  initial begin
    int cyc, hits;
    fork responder(); join_none

    // Reset state and first fetch timing
    @(posedge clk); @(posedge clk); #1;
    chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_acc", acc, 32'd0);
    rst = 1'b0;
    chk("rst_state_idle", {31'd0, mem_rd}, 32'd0);
    @(posedge clk); #1;
    chk("first_fetch_rd", {31'd0, mem_rd}, 32'd1);
    chk("first_fetch_addr", mem_addr, 32'd0);

    // Reference program, zero wait states, then random waits
    load_prog_a();
    run_prog("progA", 100);
    chk("progA_15cyc", last_cyc, 32'd15);
    chk("progA_m102", mem['h102], 32'h81);
    load_prog_a();
    run_prog("progA_wait", 50);
    chk("progA_wait_m102", mem['h102], 32'h81);
    chk("progA_wait_acc", acc, 32'h81);

    // ADD overflow followed by SKZ
    clear_mem();
    put_ins(0, 5, 'h100);
    put_ins(2, 2, 'h101);
    put_ins(4, 1, 0);
    put_ins(6, 5, 'h103);
    put_ins(8, 0, 0);
    mem['h100] = 8'hFF; mem['h101] = 8'h01; mem['h103] = 8'h55;
    run_prog("ovf_skz", 100);
    chk("ovf_acc_zero", acc, 32'h0);
    chk("ovf_pc_end", pc, 32'd10);
    hits = 0;
    foreach (rd_log[i]) if (rd_log[i] == 6 || rd_log[i] == 7) hits++;
    chk("skz_skipped_fetch", hits, 32'd0);

    // JMP to the top address: W1 fetch wraps to 0
    clear_mem();
    put_ins(0, 7, 'h1FFF);
    mem['h1FFF] = 8'h00;
    run_prog("jmp_wrap", 100);
    chk("jmp_log_size", rd_log.size(), 32'd4);
    if (rd_log.size() >= 4) begin
      chk("jmp_w0_addr", rd_log[2], 32'h1FFF);
      chk("jmp_w1_addr", rd_log[3], 32'h0);
    end

    // Random programs with random wait states
    for (int t = 0; t < 4; t++) begin
      clear_mem();
      for (int k = 0; k < 10; k++) put_ins(2 * k, $urandom_range(6, 1), 'h100 + $urandom_range(15));
      put_ins(20, 0, 0);
      put_ins(22, 0, 0);
      for (int i = 'h100; i < 'h110; i++) mem[i] = DW'($urandom);
      if (t == 0) mem['h100] = '0;
      run_prog($sformatf("rand%0d", t), 50);
    end

    // Reset asserted while a write is waiting
    clear_mem();
    put_ins(0, 5, 'h100);
    put_ins(2, 6, 'h102);
    put_ins(4, 0, 0);
    mem['h100] = 8'h3C; mem['h102] = 8'hEE;
    rdy_pct = 100; block_wr = 1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    while (!mem_wr && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("wr_reached", {31'd0, mem_wr}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("wr_still_waiting", {31'd0, mem_wr}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("wrrst_strobes", {29'd0, mem_rd, mem_wr, halted}, 32'd0);
    chk("wrrst_addr", mem_addr, 32'd0);
    chk("wrrst_wdata", mem_wdata, 32'd0);
    chk("wrrst_pc", pc, 32'd0);
    chk("wrrst_acc", acc, 32'd0);
    chk("wrrst_no_write", mem['h102], 32'hEE);
    block_wr = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("wrrst_refetch_rd", {31'd0, mem_rd}, 32'd1);
    chk("wrrst_refetch_addr", mem_addr, 32'd0);
    cyc = 0;
    while (!halted && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("wrrst_rerun_halt", {31'd0, halted}, 32'd1);
    @(negedge clk); #1;
    chk("wrrst_rerun_m102", mem['h102], 32'h3C);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
